inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded at reset.
REQ-002 Parameter IMEM_WORDS, default 2048, is the instruction memory depth in 32-bit words, used for the range check.
REQ-003 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  synchronous, active-low reset.
REQ-005 o_addr_inst  output  32  fetch address to instruction memory; equals r_pc combinationally.
REQ-006 i_inst  input  32  instruction word returned combinationally by instruction memory for o_addr_inst.
REQ-007 i_redirect_valid  input  1  branch/jump/trap redirect request.
REQ-008 i_redirect_pc  input  32  redirect target address.
REQ-009 o_valid  output  1  o_inst and o_pc hold a fetched instruction for decode.
REQ-010 i_ready  input  1  decode accepts the current o_inst/o_pc this cycle.
REQ-011 o_inst  output  32  registered instruction word.
REQ-012 o_pc  output  32  address of o_inst.
REQ-013 o_pc_plus4  output  32  o_pc + 4, combinational, modulo 2^32.
REQ-014 o_fault  output  1  fetch fault latched; fetching halted.
REQ-015 o_fault_addr  output  32  PC that caused the fault.
REQ-016 o_fetch_cnt  output  32  count of completed transfers.

Function
REQ-017 The block SHALL hold state RUN or FAULT, a 32-bit r_pc, and one output register slot (o_valid, o_inst, o_pc).
REQ-018 A transfer SHALL occur in any cycle with o_valid=1 and i_ready=1.
REQ-019 Load SHALL be true when o_valid=0 or i_ready=1.
REQ-020 Priority each edge: reset > redirect > fault check > load > hold.
REQ-021 Redirect (i_redirect_valid=1): r_pc <= i_redirect_pc, o_valid <= 0, state <= RUN, o_fault <= 0, regardless of load.
REQ-022 A transfer in the same cycle as a redirect SHALL count as completed; the slot is then emptied.
REQ-023 In RUN with load and no redirect, the fault condition SHALL be r_pc[1:0] != 0 or r_pc[31:2] >= IMEM_WORDS.
REQ-024 On fault: state <= FAULT, o_fault <= 1, o_fault_addr <= r_pc, o_valid <= 0, r_pc unchanged.
REQ-025 In RUN with load and no fault: o_inst <= i_inst, o_pc <= r_pc, o_valid <= 1, r_pc <= r_pc + 4 (32-bit wrap).
REQ-026 No load (o_valid=1, i_ready=0): o_inst, o_pc, o_valid and r_pc SHALL hold; o_inst SHALL NOT change while stalled.
REQ-027 In FAULT, o_valid SHALL stay 0 and r_pc SHALL hold until a redirect; a transfer completing in the faulting cycle SHALL still count.
REQ-028 Latency SHALL be one cycle, address to o_valid; sustained throughput with i_ready=1 SHALL be one instruction per cycle.
REQ-029 o_fetch_cnt SHALL increment by 1 on each transfer and wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-030 On i_rst_n=0 at a rising edge: r_pc <= RESET_PC, state <= RUN, o_valid <= 0, o_inst <= 32'h0000_0013 (NOP), o_pc <= 0, o_fault <= 0, o_fault_addr <= 0, o_fetch_cnt <= 0.
REQ-031 Reset asserted mid-stall or mid-fault SHALL discard the held instruction and fault state with no partial update.
REQ-032 On the first edge with i_rst_n=1, the instruction at RESET_PC SHALL be captured, giving o_valid=1 after that edge.

Verification
REQ-033 Reset release, i_ready=1, imem words 0..3 = A,B,C,D -> o_inst A,B,C,D on consecutive cycles, o_pc 0,4,8,C, o_fetch_cnt=4.
REQ-034 Stall: i_ready=0 for 3 cycles while o_inst=B -> o_inst=B and o_pc=4 held, o_addr_inst=8 held, count unchanged; the release cycle transfers B.
REQ-035 Redirect to 0x40 with o_valid=1 and i_ready=1 -> count increments, next cycle o_valid=0, o_addr_inst=0x40, following cycle o_pc=0x40.
REQ-036 Redirect to 0x42 -> one cycle later o_fault=1, o_fault_addr=0x42, o_valid=0 and stays 0; redirect to 0x80 clears o_fault and fetches 0x80.
REQ-037 Sequential fetch reaching 4*IMEM_WORDS (0x2000 by default) -> o_fault=1, o_fault_addr=0x2000, and the last valid o_pc is 0x1FFC.
REQ-038 Assert i_rst_n=0 for one cycle during a stall with o_valid=1 -> o_valid=0, o_fault=0, count=0, then refetch from RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: single-slot instruction fetch stage.
//   Holds a fetch PC (r_pc), drives it to instruction memory, and registers the
//   returned word into one output slot (o_valid/o_inst/o_pc) for decode using a
//   valid/ready handshake. Redirects override fetch. Misaligned or out-of-range
//   fetch addresses latch a fault and halt fetching until the next redirect.
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   o_addr_inst, i_inst      instruction memory address / returned word
//   i_redirect_valid/_pc     branch/jump/trap redirect request and target
//   o_valid, i_ready         output slot handshake
//   o_inst, o_pc, o_pc_plus4 fetched word, its address, address + 4
//   o_fault, o_fault_addr    fetch fault flag and faulting PC
//   o_fetch_cnt              count of completed transfers (wraps)
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_addr_inst,
  input  logic [31:0] i_inst,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_fault,
  output logic [31:0] o_fault_addr,
  output logic [31:0] o_fetch_cnt
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic [0:0]  state;
  logic [31:0] r_pc;
  logic        load;
  logic        xfer;
  logic        fault_cond;

  assign o_addr_inst = r_pc;
  assign o_pc_plus4  = o_pc + 32'd4;

  always_comb begin
    load       = !o_valid || i_ready;
    xfer       = o_valid && i_ready;
    // Word index compared zero-extended so any IMEM_WORDS value is safe.
    fault_cond = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[31:2]} >= IMEM_LIMIT);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_RUN;
      r_pc         <= RESET_PC;
      o_valid      <= 1'b0;
      o_inst       <= NOP;
      o_pc         <= '0;
      o_fault      <= 1'b0;
      o_fault_addr <= '0;
      o_fetch_cnt  <= '0;
    end else begin
      // A transfer counts even when a redirect or fault empties the slot.
      if (xfer) begin
        o_fetch_cnt <= o_fetch_cnt + 32'd1;
      end

      if (i_redirect_valid) begin
        r_pc    <= i_redirect_pc;
        o_valid <= 1'b0;
        state   <= ST_RUN;
        o_fault <= 1'b0;
      end else if (state == ST_RUN && load) begin
        if (fault_cond) begin
          state        <= ST_FAULT;
          o_fault      <= 1'b1;
          o_fault_addr <= r_pc;
          o_valid      <= 1'b0;
        end else begin
          o_inst  <= i_inst;
          o_pc    <= r_pc;
          o_valid <= 1'b1;
          r_pc    <= r_pc + 32'd4;
        end
      end else if (state == ST_FAULT) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed self-checking bench for inst_fetch with a
// combinational instruction memory model.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr_inst;
  logic [31:0] inst_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] inst_out;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_cnt;

  int unsigned tests_run;
  int unsigned tests_failed;

  localparam logic [31:0] W_A = 32'h0010_0093;
  localparam logic [31:0] W_B = 32'h0020_0113;
  localparam logic [31:0] W_C = 32'h0030_0193;
  localparam logic [31:0] W_D = 32'h0040_0213;

  inst_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(2048)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_addr_inst     (addr_inst),
    .i_inst          (inst_in),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .o_valid         (valid),
    .i_ready         (ready),
    .o_inst          (inst_out),
    .o_pc            (pc),
    .o_pc_plus4      (pc_plus4),
    .o_fault         (fault),
    .o_fault_addr    (fault_addr),
    .o_fetch_cnt     (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0: imem = W_A;
      32'h4: imem = W_B;
      32'h8: imem = W_C;
      32'hC: imem = W_D;
      default: imem = 32'hF000_0000 | a;
    endcase
  endfunction

  always_comb inst_in = imem(addr_inst);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst_n          = 1'b0;
    ready          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_inst", inst_out, 32'h0000_0013);
    check("rst_pc", pc, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("rst_addr", addr_inst, 32'd0);

    // Sequential fetch A..D at one per cycle.
    rst_n = 1'b1;
    tick();
    check("seq_valid0", 32'(valid), 32'd1);
    check("seq_inst0", inst_out, W_A);
    check("seq_pc0", pc, 32'h0);
    tick();
    check("seq_inst1", inst_out, W_B);
    check("seq_pc1", pc, 32'h4);
    tick();
    check("seq_inst2", inst_out, W_C);
    check("seq_pc2", pc, 32'h8);
    check("seq_plus4", pc_plus4, 32'hC);
    tick();
    check("seq_inst3", inst_out, W_D);
    check("seq_pc3", pc, 32'hC);
    check("seq_cnt3", fetch_cnt, 32'd3);
    tick();
    check("seq_cnt4", fetch_cnt, 32'd4);
    check("seq_pc4", pc, 32'h10);

    // Restart at 0, then stall on B.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    check("rd0_cnt", fetch_cnt, 32'd5);
    check("rd0_valid", 32'(valid), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("rd0_inst", inst_out, W_A);
    tick();
    check("pre_stall_inst", inst_out, W_B);
    check("pre_stall_cnt", fetch_cnt, 32'd6);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_inst", inst_out, W_B);
      check("stall_pc", pc, 32'h4);
      check("stall_addr", addr_inst, 32'h8);
      check("stall_cnt", fetch_cnt, 32'd6);
      check("stall_valid", 32'(valid), 32'd1);
    end
    ready = 1'b1;
    tick();
    check("release_cnt", fetch_cnt, 32'd7);
    check("release_inst", inst_out, W_C);
    check("release_pc", pc, 32'h8);

    // Redirect with a transfer in the same cycle.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    check("rd40_cnt", fetch_cnt, 32'd8);
    check("rd40_valid", 32'(valid), 32'd0);
    check("rd40_addr", addr_inst, 32'h40);
    redirect_valid = 1'b0;
    tick();
    check("rd40_pc", pc, 32'h40);
    check("rd40_inst", inst_out, 32'hF000_0040);
    check("rd40_plus4", pc_plus4, 32'h44);

    // Misaligned redirect target faults, then recovery by redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    tick();
    check("rd42_cnt", fetch_cnt, 32'd9);
    redirect_valid = 1'b0;
    tick();
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_fault_addr", fault_addr, 32'h42);
    check("mis_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mis_hold_valid", 32'(valid), 32'd0);
      check("mis_hold_fault", 32'(fault), 32'd1);
      check("mis_hold_addr", addr_inst, 32'h42);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    check("rd80_fault", 32'(fault), 32'd0);
    check("rd80_addr", addr_inst, 32'h80);
    redirect_valid = 1'b0;
    tick();
    check("rd80_valid", 32'(valid), 32'd1);
    check("rd80_pc", pc, 32'h80);
    check("rd80_inst", inst_out, 32'hF000_0080);
    check("rd80_cnt", fetch_cnt, 32'd9);

    // Range boundary: fetching past the last word faults at 0x2000.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1FF8;
    tick();
    check("rdend_cnt", fetch_cnt, 32'd10);
    redirect_valid = 1'b0;
    tick();
    check("end_pc0", pc, 32'h1FF8);
    tick();
    check("end_pc1", pc, 32'h1FFC);
    check("end_inst1", inst_out, 32'hF000_1FFC);
    check("end_cnt1", fetch_cnt, 32'd11);
    tick();
    check("oor_fault", 32'(fault), 32'd1);
    check("oor_fault_addr", fault_addr, 32'h2000);
    check("oor_valid", 32'(valid), 32'd0);
    check("oor_last_pc", pc, 32'h1FFC);
    check("oor_cnt", fetch_cnt, 32'd12);

    // Reset during a stall discards held instruction and counters.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("rst2_pre_inst", inst_out, W_A);
    ready = 1'b0;
    tick();
    check("rst2_stall_inst", inst_out, W_A);
    check("rst2_stall_cnt", fetch_cnt, 32'd12);
    rst_n = 1'b0;
    tick();
    check("rst2_valid", 32'(valid), 32'd0);
    check("rst2_fault", 32'(fault), 32'd0);
    check("rst2_cnt", fetch_cnt, 32'd0);
    check("rst2_inst", inst_out, 32'h0000_0013);
    check("rst2_addr", addr_inst, 32'h0);
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    check("rst2_refetch_valid", 32'(valid), 32'd1);
    check("rst2_refetch_pc", pc, 32'h0);
    check("rst2_refetch_inst", inst_out, W_A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
